// File: rtl/cipher_iter.sv
// rtl/cipher_iter.sv - iterative AES-128 encryptor, UNROLL rounds per clock
// Round keys are expanded on the fly alongside the state, so no key schedule storage is needed.
module cipher_iter #(
    parameter int UNROLL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0][3:0][7:0] key,
    input  logic [3:0][3:0][7:0] data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0][3:0][7:0] o,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef logic [3:0][3:0][7:0] block_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
            $error("cipher_iter: UNROLL must be 1, 2, 5 or 10");
        end
    endgenerate

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (the GF(2^8) inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic block_t next_key(input block_t k, input logic [3:0] n);
        block_t          nk;
        logic [3:0][7:0] t;
        t[0]  = sbox(k[3][1]) ^ rcon(n);
        t[1]  = sbox(k[3][2]);
        t[2]  = sbox(k[3][3]);
        t[3]  = sbox(k[3][0]);
        nk[0] = k[0] ^ t;
        nk[1] = k[1] ^ nk[0];
        nk[2] = k[2] ^ nk[1];
        nk[3] = k[3] ^ nk[2];
        return nk;
    endfunction

    function automatic block_t aes_round(input block_t s, input block_t rk, input logic last);
        block_t b;
        block_t m;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[c][r] = sbox(s[(c + r) % 4][r]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            m[c][0] = gmul(b[c][0], 8'h02) ^ gmul(b[c][1], 8'h03) ^ b[c][2] ^ b[c][3];
            m[c][1] = b[c][0] ^ gmul(b[c][1], 8'h02) ^ gmul(b[c][2], 8'h03) ^ b[c][3];
            m[c][2] = b[c][0] ^ b[c][1] ^ gmul(b[c][2], 8'h02) ^ gmul(b[c][3], 8'h03);
            m[c][3] = gmul(b[c][0], 8'h03) ^ b[c][1] ^ b[c][2] ^ gmul(b[c][3], 8'h02);
        end
        return (last ? b : m) ^ rk;
    endfunction

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    block_t     st_q;
    block_t     rk_q;
    block_t     st_n;
    block_t     rk_n;
    logic       ready_q;

    assign cnt_n = cnt + 4'(UNROLL);

    always_comb begin
        st_n = st_q;
        rk_n = rk_q;
        for (int u = 0; u < UNROLL; u++) begin
            rk_n = next_key(rk_n, cnt + 4'(u + 1));
            st_n = aes_round(st_n, rk_n, (cnt + 4'(u + 1)) == 4'd10);
        end
    end

    // ready_q is high only while idle; in DONE readiness follows the consumer directly.
    assign in_ready = ready_q | ((state == DONE) & out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            st_q      <= '0;
            rk_q      <= '0;
            o         <= '0;
            out_valid <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (in_valid && ready_q) begin
                        st_q    <= data ^ key;
                        rk_q    <= key;
                        cnt     <= 4'd0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    st_q <= st_n;
                    rk_q <= rk_n;
                    cnt  <= cnt_n;
                    if (cnt_n == 4'd10) begin
                        state     <= DONE;
                        o         <= st_n;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            st_q  <= data ^ key;
                            rk_q  <= key;
                            cnt   <= 4'd0;
                            state <= RUN;
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cipher_iter.md
CIPHER_ITER -- requirements
Module: cipher_iter

Parameters
REQ-001 SHALL provide parameter UNROLL, default 1: AES rounds computed per clock; legal values 1, 2, 5, 10.
REQ-002 SHALL stop elaboration with an error for any other UNROLL value.

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port key, input, 4x4 array of 8 bits: AES-128 cipher key; key[i][j] = FIPS-197 key byte 4*i+j.
REQ-006 SHALL have port data, input, 4x4 array of 8 bits: plaintext block; data[i][j] = FIPS-197 input byte 4*i+j (i = column).
REQ-007 SHALL have port in_valid, input, 1 bit: key/data valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept key/data.
REQ-009 SHALL have port o, output, 4x4 array of 8 bits: ciphertext, same byte mapping as data.
REQ-010 SHALL have port out_valid, output, 1 bit: o holds a completed ciphertext.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts o.

Function
REQ-012 SHALL implement AES-128 encryption per FIPS-197 (10 rounds, final round without MixColumns), bit-exact.
REQ-013 SHALL use FSM states IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready = 1 in IDLE, = out_ready in DONE, = 0 in RUN.
REQ-015 SHALL accept a block on any edge with in_valid && in_ready; it samples key and data on that edge only.
REQ-016 On accept, SHALL load state = data XOR key and round key = key, and SHALL clear the round counter and enter RUN.
REQ-017 In RUN, SHALL apply UNROLL consecutive rounds per cycle, expanding round keys on the fly via RotWord/SubWord/Rcon (Rcon 01,02,04,08,10,20,40,80,1B,36).
REQ-018 SHALL advance the round counter (0..10, 4-bit) by UNROLL per RUN cycle, and SHALL move to DONE on the edge where the counter reaches 10.
REQ-019 Latency: out_valid SHALL rise exactly 10/UNROLL edges after the accepting edge (10, 5, 2, 1 cycles).
REQ-020 In DONE, o and out_valid SHALL remain stable while out_ready = 0, with no timeout.
REQ-021 On a DONE edge with out_ready = 1 and in_valid = 0, SHALL go to IDLE and clear out_valid.
REQ-022 On a DONE edge with out_ready = 1 and in_valid = 1, SHALL retire the output and accept the new block on the same edge (go to RUN, out_valid = 0); there are no bubble cycles.
REQ-023 SHALL ignore in_valid, key and data changes during RUN.
REQ-024 Throughput: one block per 10/UNROLL + 1 cycles with out_ready held at 1.
REQ-025 o SHALL be valid only when out_valid = 1; its value is otherwise unspecified but SHALL not toggle in IDLE.

Reset
REQ-026 While rst = 0, SHALL force the FSM to IDLE, round counter to 0, state and o registers to 0, out_valid = 0, and in_ready = 0.
REQ-027 After rst deasserts, SHALL raise in_ready at the first clk edge in IDLE.
REQ-028 Reset mid-RUN or in DONE SHALL abort the block; no output is produced for it.

Verification
REQ-029 Bench SHALL check FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> o 3925841d02dc09fbdc118597196a0b32, with out_valid 10 cycles after accept (UNROLL=1).
REQ-030 Bench SHALL check App. C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> o 69c4e0d86a7b0430d8cdb78070b4c55a, for UNROLL = 1, 2, 5, 10 at latency 10, 5, 2, 1.
REQ-031 Bench SHALL check backpressure: out_ready = 0 for 7 cycles in DONE -> o and out_valid stable, in_ready = 0; then out_ready = 1 -> IDLE next edge.
REQ-032 Bench SHALL check back-to-back: App. B then App. C.1 with in_valid and out_ready held at 1 -> second accept on the same edge as the first retire, both outputs correct, 11-cycle spacing (UNROLL=1).
REQ-033 Bench SHALL check reset mid-run: rst = 0 at round 4 -> out_valid = 0 and in_ready = 0 immediately, in_ready = 1 after release, and the next block (App. B) is correct.
REQ-034 Bench SHALL check RUN isolation: key and data changed every cycle during RUN -> the result equals that of the sampled inputs.
